// File: rtl/prime_pkg.sv
// -----------------------------------------------------------------------------
// prime_pkg
// Shared definitions for the prime search sequencer and its sub-blocks:
//   - COUNTER_WIDTH / COUNTER_MAX : candidate width and search-limit clamp
//   - candidate_t                 : candidate / result value type
//   - state_t                     : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package prime_pkg;

    localparam int unsigned COUNTER_WIDTH = 20;
    localparam int unsigned COUNTER_MAX   = 1000000;

    typedef logic [COUNTER_WIDTH-1:0] candidate_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EVAL,
        ST_REQ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/prime_search_sequencer_if.sv
// -----------------------------------------------------------------------------
// prime_search_sequencer_if
// Link between the sequencer (master) and the prime counter bank (slave).
//   CounterLoad   : master -> bank, one-cycle reinitialise pulse
//   CounterEnable : master -> bank, all ones while a search is running
//   Candidate     : master -> bank, value under test, valid with CheckReq
//   CheckReq      : master -> bank, divisibility check request
//   CheckAck      : bank -> master, verdict available this cycle
//   Composite     : bank -> master, qualified by CheckAck
// -----------------------------------------------------------------------------
interface prime_search_sequencer_if #(
    parameter int NUM_COUNTERS  = 10,
    parameter int COUNTER_WIDTH = prime_pkg::COUNTER_WIDTH
);
    logic                     CounterLoad;
    logic [NUM_COUNTERS-1:0]  CounterEnable;
    logic [COUNTER_WIDTH-1:0] Candidate;
    logic                     CheckReq;
    logic                     CheckAck;
    logic                     Composite;

    modport master (
        output CounterLoad, CounterEnable, Candidate, CheckReq,
        input  CheckAck, Composite
    );

    modport slave (
        input  CounterLoad, CounterEnable, Candidate, CheckReq,
        output CheckAck, Composite
    );
endinterface

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Saturating up-counter with synchronous clear and count enable.
//   clk, Reset_n : clock, asynchronous active-low reset
//   i_clear      : zero the count (wins over i_enable)
//   i_enable     : count this cycle
//   o_count      : current count, sticks at all ones
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prime_search_sequencer.sv
// -----------------------------------------------------------------------------
// prime_search_sequencer
// Walks a candidate down from the clamped limit, skipping evens locally and
// asking the counter bank about each odd one, to find the largest prime at or
// below PrimeSearchLimit.
//   clk, Reset_n     : clock, asynchronous active-low reset
//   Start, Abort     : begin a search (IDLE/DONE only) / cancel a running one
//   PrimeSearchLimit : upper bound, sampled when Start is accepted
//   bank             : master side of the counter bank link
//   Busy, Done       : search running / result valid (held until next Start)
//   Found            : a prime <= limit exists
//   LargestPrime     : result, 0 when Found is 0
//   CycleCount       : Busy cycles of the last search, saturating
// -----------------------------------------------------------------------------
module prime_search_sequencer #(
    parameter int NUM_COUNTERS  = 10,
    parameter int COUNTER_WIDTH = prime_pkg::COUNTER_WIDTH,
    parameter int COUNTER_MAX   = prime_pkg::COUNTER_MAX,
    parameter int TIMER_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      Reset_n,
    input  logic                      Start,
    input  logic                      Abort,
    input  logic [COUNTER_WIDTH-1:0]  PrimeSearchLimit,
    prime_search_sequencer_if.master  bank,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Found,
    output logic [COUNTER_WIDTH-1:0]  LargestPrime,
    output logic [TIMER_WIDTH-1:0]    CycleCount
);

    import prime_pkg::*;

    localparam logic [COUNTER_WIDTH-1:0] LP_MAX = COUNTER_WIDTH'(COUNTER_MAX);
    localparam logic [COUNTER_WIDTH-1:0] LP_TWO = COUNTER_WIDTH'(2);

    state_t                   r_state,     w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_candidate, w_candidate_nxt;
    logic [COUNTER_WIDTH-1:0] r_largest,   w_largest_nxt;
    logic                     r_done,      w_done_nxt;
    logic                     r_found,     w_found_nxt;
    logic                     r_busy,      w_busy_nxt;
    logic                     r_check_req, w_check_req_nxt;
    logic                     r_load,      w_load_nxt;
    logic                     w_timer_clr;
    logic                     w_active;

    assign w_active = (r_state == ST_LOAD) || (r_state == ST_EVAL) || (r_state == ST_REQ);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_candidate_nxt = r_candidate;
        w_largest_nxt   = r_largest;
        w_done_nxt      = r_done;
        w_found_nxt     = r_found;
        w_timer_clr     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    w_state_nxt     = ST_LOAD;
                    w_candidate_nxt = (PrimeSearchLimit > LP_MAX) ? LP_MAX : PrimeSearchLimit;
                    w_largest_nxt   = '0;
                    w_done_nxt      = 1'b0;
                    w_found_nxt     = 1'b0;
                    w_timer_clr     = 1'b1;
                end
            end
            ST_LOAD: w_state_nxt = ST_EVAL;
            ST_EVAL: begin
                if (r_candidate < LP_TWO) begin
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_found_nxt   = 1'b0;
                    w_largest_nxt = '0;
                end else if (r_candidate == LP_TWO) begin
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_found_nxt   = 1'b1;
                    w_largest_nxt = LP_TWO;
                end else if (!r_candidate[0]) begin
                    w_candidate_nxt = r_candidate - COUNTER_WIDTH'(1);
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bank.CheckAck) begin
                    if (!bank.Composite) begin
                        w_state_nxt   = ST_DONE;
                        w_done_nxt    = 1'b1;
                        w_found_nxt   = 1'b1;
                        w_largest_nxt = r_candidate;
                    end else begin
                        // Candidate is odd and >= 3 here, so this stays >= 1.
                        w_candidate_nxt = r_candidate - LP_TWO;
                        w_state_nxt     = ST_EVAL;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort overrides whatever the active state decided.
        if (Abort && w_active) begin
            w_state_nxt     = ST_IDLE;
            w_candidate_nxt = r_candidate;
            w_largest_nxt   = '0;
            w_done_nxt      = 1'b0;
            w_found_nxt     = 1'b0;
        end

        // Moore outputs are decoded from the next state and registered so
        // they come straight off flops.
        w_busy_nxt      = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_EVAL) ||
                          (w_state_nxt == ST_REQ);
        w_check_req_nxt = (w_state_nxt == ST_REQ);
        w_load_nxt      = (w_state_nxt == ST_LOAD);
    end

    // NOTE: every register, datapath included, is cleared by the async reset
    // so outputs are defined immediately, before any clock edge.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_candidate <= '0;
            r_largest   <= '0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_busy      <= 1'b0;
            r_check_req <= 1'b0;
            r_load      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_candidate <= w_candidate_nxt;
            r_largest   <= w_largest_nxt;
            r_done      <= w_done_nxt;
            r_found     <= w_found_nxt;
            r_busy      <= w_busy_nxt;
            r_check_req <= w_check_req_nxt;
            r_load      <= w_load_nxt;
        end
    end

    cycle_timer #(.WIDTH(TIMER_WIDTH)) u_cycle_timer (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .i_clear  (w_timer_clr),
        .i_enable (r_busy),
        .o_count  (CycleCount)
    );

    assign bank.CounterLoad   = r_load;
    assign bank.CounterEnable = {NUM_COUNTERS{r_busy}};
    assign bank.Candidate     = r_candidate;
    assign bank.CheckReq      = r_check_req;

    assign Busy         = r_busy;
    assign Done         = r_done;
    assign Found        = r_found;
    assign LargestPrime = r_largest;

endmodule
